// File: rtl/skid_pkg.sv
// skid_pkg: shared types for the skid buffer slice.
// State encodings, count width and output decode helpers.
package skid_pkg;

  localparam int COUNT_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  function automatic logic [COUNT_W-1:0] occupancy(state_t s);
    logic [COUNT_W-1:0] n;
    n = '0;
    unique case (s)
      ST_EMPTY: n = 2'd0;
      ST_ONE:   n = 2'd1;
      ST_FULL:  n = 2'd2;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic ready_of(state_t s);
    return s != ST_FULL;
  endfunction

  function automatic logic valid_of(state_t s);
    return s != ST_EMPTY;
  endfunction

endpackage

// File: rtl/skid_buffer_pipe_reg.sv
// pipe_reg: WIDTH-bit enable register with synchronous
// active-low clear; holds either the main or the skid beat.
module pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // clear dominates load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/skid_buffer.sv
// skid_buffer: two-entry valid/ready slice, all outputs
// registered; skid entry absorbs the in-flight beat on stall.
module skid_buffer
  import skid_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  input  logic [WIDTH-1:0]   s_data,
  output logic               s_ready,
  output logic               m_valid,
  output logic [WIDTH-1:0]   m_data,
  input  logic               m_ready,
  output logic [COUNT_W-1:0] count
);

  state_t           state;
  state_t           nxt;
  logic             in_hs;
  logic             out_hs;
  logic             main_en;
  logic             skid_en;
  logic             use_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign in_hs  = s_valid && s_ready;
  assign out_hs = m_valid && m_ready;
  assign main_d = use_skid ? skid_q : s_data;

  // next state and register load enables
  always_comb begin
    nxt      = state;
    main_en  = 1'b0;
    skid_en  = 1'b0;
    use_skid = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (in_hs) begin
          main_en = 1'b1;
          nxt     = ST_ONE;
        end
      end
      ST_ONE: begin
        unique case ({in_hs, out_hs})
          2'b10: begin
            skid_en = 1'b1;
            nxt     = ST_FULL;
          end
          2'b01: begin
            nxt = ST_EMPTY;
          end
          2'b11: begin
            main_en = 1'b1;
          end
          default: begin
            nxt = ST_ONE;
          end
        endcase
      end
      ST_FULL: begin
        if (out_hs) begin
          main_en  = 1'b1;
          use_skid = 1'b1;
          nxt      = ST_ONE;
        end
      end
      default: begin
        nxt = ST_EMPTY;
      end
    endcase
  end

  // state and handshake outputs registered from next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      count   <= '0;
    end else begin
      state   <= nxt;
      s_ready <= ready_of(nxt);
      m_valid <= valid_of(nxt);
      count   <= occupancy(nxt);
    end
  end

  pipe_reg #(
    .WIDTH(WIDTH)
  ) u_main (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (main_en),
    .d    (main_d),
    .q    (m_data)
  );

  pipe_reg #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (skid_en),
    .d    (s_data),
    .q    (skid_q)
  );

endmodule

// File: tb/tb_skid_buffer.sv
// tb_skid_buffer: scenario tasks plus a scoreboard monitor
// that matches every accepted beat against the output stream.
module tb_skid_buffer;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [1:0] count;

  int checks;
  int fails;

  logic [7:0] sb[$];
  logic       stall_v;
  logic [7:0] stall_d;

  skid_buffer #(
    .WIDTH(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_data (s_data),
    .s_ready(s_ready),
    .m_valid(m_valid),
    .m_data (m_data),
    .m_ready(m_ready),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: push on input handshake, pop on output handshake
  always @(negedge clk) begin
    logic [7:0] exp;
    if (!rst_n) begin
      sb.delete();
      stall_v = 1'b0;
    end else begin
      checks++;
      if (count > 2'd2 || m_valid !== (count != 2'd0)) begin
        fails++;
        $display("FAIL occupancy: count=%0d m_valid=%b", count, m_valid);
      end
      if (stall_v && m_valid) begin
        checks++;
        if (m_data !== stall_d) begin
          fails++;
          $display("FAIL stable: m_data=%h required %h", m_data, stall_d);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: m_data=%h with no beat pending", m_data);
        end else begin
          exp = sb.pop_front();
          if (m_data !== exp) begin
            fails++;
            $display("FAIL order: m_data=%h required %h", m_data, exp);
          end
        end
      end
      if (s_valid && s_ready) sb.push_back(s_data);
      stall_v = m_valid && !m_ready;
      stall_d = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    m_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (m_valid !== 1'b0 || count !== 2'd0 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset: m_valid=%b count=%0d s_ready=%b required 0 0 0",
               m_valid, count, s_ready);
    end
    rst_n = 1'b1;
    tick();
    s_valid = 1'b0;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: s_ready=%b m_valid=%b required 1 0",
               s_ready, m_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (m_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_no_beat: m_valid=%b required 0", m_valid);
      end
    end
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h3C;
    tick();
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h3C || count !== 2'd1) begin
      fails++;
      $display("FAIL single: m_valid=%b m_data=%h count=%0d required 1 3c 1",
               m_valid, m_data, count);
    end
    tick();
    checks++;
    if (count !== 2'd0 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_drain: count=%0d m_valid=%b required 0 0",
               count, m_valid);
    end
  endtask

  task automatic test_stream();
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_data = 8'(i);
      checks++;
      if (s_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_ready: beat %0d s_ready=%b required 1", i, s_ready);
      end
      tick();
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        fails++;
        $display("FAIL stream: m_valid=%b m_data=%h required 1 %h",
                 m_valid, m_data, 8'(i));
      end
    end
    s_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    logic [7:0] want[3];
    want[0] = 8'h02;
    want[1] = 8'h03;
    want[2] = 8'h04;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h01;
    tick();
    m_ready = 1'b0;
    s_data  = 8'h02;
    tick();
    s_data = 8'h03;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (count !== 2'd2 || s_ready !== 1'b0 || m_data !== 8'h01) begin
        fails++;
        $display("FAIL stall: count=%0d s_ready=%b m_data=%h required 2 0 01",
                 count, s_ready, m_data);
      end
      tick();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 1) s_data = 8'h04;
      if (i == 2) s_valid = 1'b0;
      checks++;
      if (m_valid !== 1'b1 || m_data !== want[i]) begin
        fails++;
        $display("FAIL stall_release: m_valid=%b m_data=%h required 1 %h",
                 m_valid, m_data, want[i]);
      end
    end
    s_valid = 1'b0;
    tick();
    checks++;
    if (m_valid !== 1'b0 || count !== 2'd0) begin
      fails++;
      $display("FAIL stall_drain: m_valid=%b count=%0d required 0 0",
               m_valid, count);
    end
  endtask

  task automatic test_random();
    int sent;
    int cyc;
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      m_ready = 1'($urandom_range(0, 1));
      if (s_valid && s_ready) sent++;
      tick();
      cyc++;
    end
    checks++;
    if (sent < 1000) begin
      fails++;
      $display("FAIL random_budget: sent=%0d required 1000", sent);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL random_drain: pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_mid_reset();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h11;
    tick();
    s_data = 8'h22;
    tick();
    s_data = 8'h33;
    checks++;
    if (count !== 2'd2) begin
      fails++;
      $display("FAIL mid_full: count=%0d required 2", count);
    end
    rst_n   = 1'b0;
    m_ready = 1'b1;
    tick();
    rst_n   = 1'b1;
    s_valid = 1'b0;
    checks++;
    if (count !== 2'd0 || m_valid !== 1'b0 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: count=%0d m_valid=%b s_ready=%b required 0 0 0",
               count, m_valid, s_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (m_valid !== 1'b0) begin
        fails++;
        $display("FAIL mid_reset_leak: m_valid=%b m_data=%h required no beat",
                 m_valid, m_data);
      end
    end
    checks++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_ready: s_ready=%b required 1", s_ready);
    end
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    stall_v = 1'b0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_stream();
    test_stall();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
